// File: rtl/pipe_muldiv.sv
// pipe_muldiv: multi-cycle multiply/divide unit owning the HI/LO pair.
// Iterative shift-add multiply and restoring divide, 32 iterations each,
// followed by a sign-fix cycle. Optional macro MULDIV_FAST_MUL_EN replaces
// the iterative multiply with a single-cycle multiplier (divide unchanged).
module pipe_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  AluFunc,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        HiWrite,
    input  logic        LoWrite,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  cnt;
    logic        signed_op;
    logic        is_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] raw_a;
    logic [31:0] raw_b;
    logic [63:0] acc;

    logic        valid_start;
    logic        fast_mul;
    logic [31:0] in_mag_a;
    logic [31:0] in_mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [63:0] acc_step;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Two's-complement absolute value; 0x80000000 maps to itself (read unsigned).
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    assign valid_start = start && (AluFunc[3:2] == 2'b11);
    assign in_mag_a    = magnitude(a, ~AluFunc[0]);
    assign in_mag_b    = magnitude(b, ~AluFunc[0]);
    assign busy        = (state != IDLE);

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul = valid_start && !AluFunc[1];
`else
    assign fast_mul = 1'b0;
`endif

    // One iteration: multiply adds the multiplicand into the upper half and
    // shifts right; divide shifts the remainder left and tries a subtract.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mag_a : 32'd0)};
        div_shift = {acc[63:32], acc[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
        acc_step  = acc;
        if (is_div) begin
            if (!div_diff[33]) begin
                acc_step = {div_diff[31:0], acc[30:0], 1'b1};
            end else begin
                acc_step = {div_shift[31:0], acc[30:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc[31:1]};
        end
    end

    // Sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        res_hi = acc[63:32];
        res_lo = acc[31:0];
        if (is_div) begin
            if (raw_b == 32'd0) begin
                res_hi = raw_a;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_lo = (signed_op && (raw_a[31] ^ raw_b[31])) ? (32'd0 - acc[31:0]) : acc[31:0];
                res_hi = (signed_op && raw_a[31]) ? (32'd0 - acc[63:32]) : acc[63:32];
            end
        end else begin
            if (signed_op && (raw_a[31] ^ raw_b[31])) begin
                {res_hi, res_lo} = 64'd0 - acc;
            end else begin
                {res_hi, res_lo} = acc;
            end
        end
    end

    // Next-state logic for the IDLE -> RUN -> FIX -> IDLE sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (valid_start) begin
                    state_next = fast_mul ? FIX : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (cnt == 6'd31) begin
                    state_next = FIX;
                end else begin
                    state_next = RUN;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latch, iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 6'd0;
            signed_op <= 1'b0;
            is_div    <= 1'b0;
            mag_a     <= 32'd0;
            mag_b     <= 32'd0;
            raw_a     <= 32'd0;
            raw_b     <= 32'd0;
            acc       <= 64'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_start) begin
                        signed_op <= ~AluFunc[0];
                        is_div    <= AluFunc[1];
                        mag_a     <= in_mag_a;
                        mag_b     <= in_mag_b;
                        raw_a     <= a;
                        raw_b     <= b;
                        cnt       <= 6'd0;
`ifdef MULDIV_FAST_MUL_EN
                        if (fast_mul) begin
                            acc <= {32'd0, in_mag_a} * {32'd0, in_mag_b};
                        end else begin
                            acc <= {32'd0, in_mag_a};
                        end
`else
                        if (AluFunc[1]) begin
                            acc <= {32'd0, in_mag_a};
                        end else begin
                            acc <= {32'd0, in_mag_b};
                        end
`endif
                    end else begin
                        if (HiWrite) hi <= a;
                        if (LoWrite) lo <= a;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: begin
                    cnt <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_muldiv.sv
// Self-checking bench for pipe_muldiv: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_pipe_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  AluFunc;
    logic [31:0] a;
    logic [31:0] b;
    logic        HiWrite;
    logic        LoWrite;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec;
    int n_err;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    pipe_muldiv dut (
        .clk(clk), .rst(rst), .start(start), .AluFunc(AluFunc),
        .a(a), .b(b), .HiWrite(HiWrite), .LoWrite(LoWrite),
        .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: {hi, lo} from plain signed/unsigned arithmetic.
    function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        int sa;
        int sb;
        longint sp;
        logic [31:0] q;
        logic [31:0] r;
        sa = av;
        sb = bv;
        case (op)
            4'b1100: begin sp = longint'(sa) * longint'(sb); return sp; end
            4'b1101: return {32'd0, av} * {32'd0, bv};
            4'b1110: begin
                if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
                if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            4'b1111: begin
                if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
                return {av % bv, av / bv};
            end
            default: return {exp_hi, exp_lo};
        endcase
    endfunction

    function automatic int exp_busy(input logic [3:0] op);
`ifdef MULDIV_FAST_MUL_EN
        return (op[1] == 1'b0) ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input logic with_wr, input logic disturb);
        int n;
        logic [63:0] r;
        @(negedge clk);
        start = 1'b1; AluFunc = op; a = av; b = bv;
        HiWrite = with_wr; LoWrite = with_wr;
        @(negedge clk);
        start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0; a = 32'h0BAD_F00D; b = 32'h0;
        check("hold_hi", hi, exp_hi);
        check("hold_lo", lo, exp_lo);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (disturb && n == 5) begin
                start = 1'b1; AluFunc = 4'b1100; a = 32'h5555_5555; b = 32'd3; HiWrite = 1'b1;
            end else if (disturb && n == 6) begin
                start = 1'b0; HiWrite = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; HiWrite = 1'b0;
        r = ref_model(op, av, bv);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        check("busy_cycles", 64'(n), 64'(exp_busy(op)));
        check("res_hi", hi, exp_hi);
        check("res_lo", lo, exp_lo);
    endtask

    task automatic move_to(input logic hw, input logic lw, input logic [31:0] v);
        @(negedge clk);
        HiWrite = hw; LoWrite = lw; a = v;
        @(negedge clk);
        HiWrite = 1'b0; LoWrite = 1'b0;
        if (hw) exp_hi = v;
        if (lw) exp_lo = v;
        check("mt_busy", 64'(busy), 64'd0);
        check("mt_hi", hi, exp_hi);
        check("mt_lo", lo, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; AluFunc = 4'd0; a = 32'd0; b = 32'd0;
        HiWrite = 1'b0; LoWrite = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", hi, 64'd0);
        check("rst_lo", lo, 64'd0);

        move_to(1'b1, 1'b0, 32'h1234_5678);
        move_to(1'b0, 1'b1, 32'h9ABC_DEF0);
        move_to(1'b1, 1'b1, 32'hCAFE_0001);

        run_op(4'b1100, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        run_op(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(4'b1110, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(4'b1111, 32'd100, 32'd0, 1'b0, 1'b1);
        run_op(4'b1110, 32'hFFFF_FF00, 32'd0, 1'b1, 1'b0);

        // Reset in the middle of a divide abandons it.
        move_to(1'b1, 1'b0, 32'hAAAA_0000);
        @(negedge clk);
        start = 1'b1; AluFunc = 4'b1110; a = 32'd50; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", hi, 64'd0);
        check("midrst_lo", lo, 64'd0);
        run_op(4'b1111, 32'd50, 32'd7, 1'b0, 1'b0);

        // Invalid code with start is ignored.
        @(negedge clk);
        start = 1'b1; AluFunc = 4'b0110; a = 32'h1111_2222;
        @(negedge clk);
        start = 1'b0;
        check("badop_busy", 64'(busy), 64'd0);
        check("badop_hi", hi, exp_hi);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            op = {2'b11, 2'($urandom_range(0, 3))};
            run_op(op, pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
